// File: rtl/uart_rx_os.sv
// ============================================================================
//  Module   : uart_rx_os
//  Brief    : 8N1 UART receive front end with 3-sample majority voting,
//             framing-error flagging and break suppression.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_os #(
    parameter int DIV = 861,
    parameter int CW  = $clog2(DIV)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CW-1:0] c_half    = CW'(DIV / 2);
    localparam logic [CW-1:0] c_half_m1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] c_half_p1 = CW'(DIV / 2 + 1);
    localparam logic [CW-1:0] c_last    = CW'(DIV - 1);
    localparam logic [CW-1:0] c_last_m1 = CW'(DIV - 2);
    localparam logic [CW-1:0] c_one     = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic          r_sync1;
    logic          r_rxs;
    logic          r_rxs_d;
    logic [CW-1:0] r_cnt;
    logic          r_s0;
    logic          r_s1;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shreg;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ferr;
    logic          r_busy;

    logic          w_fall;
    logic          w_maj;
    logic          w_decide;
    logic [CW-1:0] w_smp0_at;
    logic [CW-1:0] w_smp1_at;
    logic          w_cnt_clr;
    logic          w_cnt_one;
    logic          w_shift;
    logic          w_fire;
    logic          w_ferr;

    assign w_fall = r_rxs_d & ~r_rxs;
    // Third sample is the live synchronised line on the decision cycle.
    assign w_maj  = (r_s0 & r_s1) | (r_s0 & r_rxs) | (r_s1 & r_rxs);

    // START centres at DIV/2; DATA/STOP centre at DIV-1 and decide after the wrap.
    always_comb begin
        w_smp0_at = c_last_m1;
        w_smp1_at = c_last;
        w_decide  = (r_cnt == '0);
        if (r_state == S_START) begin
            w_smp0_at = c_half_m1;
            w_smp1_at = c_half;
            w_decide  = (r_cnt == c_half_p1);
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_clr = 1'b0;
        w_cnt_one = 1'b0;
        w_shift   = 1'b0;
        w_fire    = 1'b0;
        w_ferr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_next    = S_START;
                    w_cnt_clr = 1'b1;
                end
            end
            S_START: begin
                if (w_decide) begin
                    if (w_maj) begin
                        w_next = S_IDLE;
                    end else begin
                        // Counter reads 1 next cycle so DIV-1 lands one bit after the start centre.
                        w_next    = S_DATA;
                        w_cnt_one = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_decide) begin
                    w_shift = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_decide) begin
                    if (w_maj) begin
                        w_fire = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_ferr = 1'b1;
                        w_next = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (r_rxs) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_rxs     <= 1'b1;
            r_rxs_d   <= 1'b1;
            r_cnt     <= '0;
            r_s0      <= 1'b0;
            r_s1      <= 1'b0;
            r_bit_idx <= 3'd0;
            r_shreg   <= 8'h00;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_sync1 <= rxd;
            r_rxs   <= r_sync1;
            r_rxs_d <= r_rxs;

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_one) begin
                r_cnt <= c_one;
            end else if (r_cnt == c_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_one;
            end

            if (r_cnt == w_smp0_at) begin
                r_s0 <= r_rxs;
            end
            if (r_cnt == w_smp1_at) begin
                r_s1 <= r_rxs;
            end

            if (w_cnt_one) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_shift) begin
                r_shreg <= {w_maj, r_shreg[7:1]};
            end

            if (w_fire) begin
                r_data <= r_shreg;
            end
            r_valid <= w_fire;
            r_ferr  <= w_ferr;
            r_busy  <= (w_next != S_IDLE);
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign busy      = r_busy;

endmodule

`default_nettype wire
